pipe_add_sub: RTL and testbench

Parametrised, pipelined N-bit adder/subtractor with a valid/ready handshake. It is the multi-bit, sequential successor to the one-bit full adder cell. The carry chain is split into STAGES equal chunks, with one chunk resolved per clock, so wide operands close timing at high clock rates. The block sits between an operand producer and a result consumer; both follow the standard valid/ready streaming rules.

---
 rtl/pipe_add_sub.sv | 113 +++++++++++
 tb/tb_pipe_add_sub.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_add_sub.sv
// pipe_add_sub: pipelined WIDTH-bit adder/subtractor with a valid/ready handshake.
// The carry chain is cut into STAGES chunks of CHUNK bits. Stage k resolves
// chunk k and passes its carry-out to stage k+1 one clock later.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready = pipeline advances)
//   a, b, cin, sub        operands, carry/borrow-in, 0 = add / 1 = subtract
//   out_valid / out_ready result handshake
//   sum, cout, overflow   result, carry-out (sub: 1 = no borrow), signed overflow
module pipe_add_sub #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned CHUNK = WIDTH / STAGES;
  localparam int unsigned CW    = CHUNK + 1;
  localparam int unsigned LAST  = STAGES - 1;

  // Per-stage registers: valid, chunk carry-out, skewed operands, partial result.
  logic             v_q [STAGES];
  logic             c_q [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] r_q [STAGES];
  logic             ovf_q;

  // Per-stage inputs and next values.
  logic             v_in [STAGES];
  logic             c_in [STAGES];
  logic [WIDTH-1:0] a_in [STAGES];
  logic [WIDTH-1:0] b_in [STAGES];
  logic [WIDTH-1:0] r_in [STAGES];
  logic [WIDTH-1:0] r_nx [STAGES];
  logic             c_nx [STAGES];
  logic [CW-1:0]    part [STAGES];
  logic             msb_cin;
  logic             ovf_nx;
  logic             advance;

  // Global stall: everything moves when the output slot is free or draining.
  assign advance  = !v_q[LAST] | out_ready;
  assign in_ready = advance;

  // Chunk adders; stage 0 takes the live operands with B and c0 conditioned by sub.
  always_comb begin
    v_in[0] = in_valid;
    c_in[0] = cin ^ sub;
    a_in[0] = a;
    b_in[0] = sub ? ~b : b;
    r_in[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      v_in[k] = v_q[k-1];
      c_in[k] = c_q[k-1];
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      r_in[k] = r_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      part[k] = {1'b0, a_in[k][k*CHUNK +: CHUNK]}
              + {1'b0, b_in[k][k*CHUNK +: CHUNK]}
              + CW'(c_in[k]);
      r_nx[k] = r_in[k];
      r_nx[k][k*CHUNK +: CHUNK] = part[k][CHUNK-1:0];
      c_nx[k] = part[k][CHUNK];
    end
    // Carry into the MSB recovered from the MSB sum bit and its operand bits.
    msb_cin = r_nx[LAST][WIDTH-1] ^ a_in[LAST][WIDTH-1] ^ b_in[LAST][WIDTH-1];
    ovf_nx  = msb_cin ^ c_nx[LAST];
  end

  // Stage registers; all load together on advance, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        r_q[k] <= '0;
      end
      ovf_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= v_in[k];
        c_q[k] <= c_nx[k];
        a_q[k] <= a_in[k];
        b_q[k] <= b_in[k];
        r_q[k] <= r_nx[k];
      end
      ovf_q <= ovf_nx;
    end
  end

  assign out_valid = v_q[LAST];
  assign sum       = r_q[LAST];
  assign cout      = c_q[LAST];
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_pipe_add_sub.sv
// tb_pipe_add_sub: directed and random checks of pipe_add_sub at WIDTH=8, STAGES=2.
module tb_pipe_add_sub;

  localparam int unsigned W = 8;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           t;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  pipe_add_sub #(.WIDTH(W), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           n_acc = 0;
  bit           lat_chk = 1'b0;
  bit           stalled_prev = 1'b0;
  logic [W-1:0] prev_s;
  logic         prev_c;
  logic         prev_o;
  exp_t         q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Integer reference: unsigned range decides cout, signed range decides overflow.
  function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                 input logic ic, input logic is);
    exp_t e;
    int ua, ub, sa, sb, ci, r, sr;
    ua = int'(ia); ub = int'(ib); ci = int'(ic);
    sa = int'($signed(ia)); sb = int'($signed(ib));
    r  = is ? ua - ub - ci : ua + ub + ci;
    sr = is ? sa - sb - ci : sa + sb + ci;
    e.s = W'(r);
    e.c = is ? (ua >= ub + ci) : (r > 255);
    e.o = (sr > 127) || (sr < -128);
    e.t = 0;
    return e;
  endfunction

  // One cycle: drive at negedge, check outputs, track handshakes.
  task automatic step_x(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic ic, input logic is, input logic ordy,
                        input bit use_exp, input logic [W-1:0] es,
                        input logic ec, input logic eo);
    logic rdy;
    exp_t e;
    @(negedge clk);
    in_valid = iv; a = ia; b = ib; cin = ic; sub = is; out_ready = ordy;
    #1;
    rdy = !out_valid || ordy;
    chk("in_ready", 32'(in_ready), 32'(rdy));
    if (stalled_prev) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_sum", 32'(sum), 32'(prev_s));
      chk("stall_flags", 32'({cout, overflow}), 32'({prev_c, prev_o}));
    end
    if (out_valid && q.size() == 0) begin
      chk("spurious_valid", 32'(out_valid), 32'd0);
    end else if (out_valid && ordy) begin
      e = q.pop_front();
      chk("sum", 32'(sum), 32'(e.s));
      chk("cout", 32'(cout), 32'(e.c));
      chk("overflow", 32'(overflow), 32'(e.o));
      if (lat_chk) chk("latency", 32'(cyc - e.t), 32'd2);
    end
    stalled_prev = out_valid && !ordy;
    prev_s = sum; prev_c = cout; prev_o = overflow;
    if (iv && rdy) begin
      e = model(ia, ib, ic, is);
      if (use_exp) begin e.s = es; e.c = ec; e.o = eo; end
      e.t = cyc;
      q.push_back(e);
      n_acc++;
    end
    cyc++;
  endtask

  task automatic step(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                      input logic ic, input logic is, input logic ordy);
    step_x(iv, ia, ib, ic, is, ordy, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && q.size() > 0; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    out_ready = 1'b0;
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_flags", 32'({cout, overflow}), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    #9 rst_n = 1'b1;

    // Directed vectors with hand-computed results; latency checked too.
    lat_chk = 1'b1;
    step_x(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
    drain();
    step_x(1'b1, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 8'h80, 1'b0, 1'b1);
    step_x(1'b1, 8'h7F, 8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 8'h81, 1'b0, 1'b1);
    step_x(1'b1, 8'h05, 8'h07, 1'b0, 1'b1, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
    step_x(1'b1, 8'h80, 8'h01, 1'b0, 1'b1, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1);
    step_x(1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
    drain();

    // Back-to-back streaming, one result per cycle, fixed latency.
    for (int i = 0; i < 256; i++)
      step(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    drain();
    lat_chk = 1'b0;

    // Backpressure with a full pipeline and a beat waiting at the input.
    step(1'b1, 8'h11, 8'h22, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h33, 8'h44, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 8'hA5, 8'h5A, 1'b0, 1'b1, 1'b0);
    step(1'b1, 8'hA5, 8'h5A, 1'b0, 1'b1, 1'b1);
    drain();

    // Random out_ready toggling until 1000 beats have been accepted.
    n_acc = 0;
    for (int i = 0; i < 6000 && n_acc < 1000; i++)
      step(1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom));
    chk("rand_beats", 32'(n_acc >= 1000), 32'd1);
    drain();

    // Asynchronous reset with two beats in flight.
    step(1'b1, 8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h56, 8'h78, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #2;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_sum", 32'(sum), 32'd0);
    chk("mid_rst_flags", 32'({cout, overflow}), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    q.delete();
    stalled_prev = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    lat_chk = 1'b1;
    step_x(1'b1, 8'h9C, 8'h64, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
